// File: rtl/conv_line_buffer_ctrl.sv
// conv_line_buffer_ctrl: buffers raster pixels into 4 rotating lines and streams 3x3 windows to the blur datapath
module conv_line_buffer_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [PIX_W-1:0]     i_pixel_data,
    input  logic                 i_pixel_valid,
    input  logic                 i_rd_en,
    output logic [9*PIX_W-1:0]   o_window_data,
    output logic                 o_window_valid,
    output logic                 o_line_done,
    output logic                 o_overflow
);
    localparam int PW = $clog2(IMG_WIDTH);
    localparam int CW = $clog2(4*IMG_WIDTH+1);
    localparam logic [CW-1:0] FULL  = CW'(4*IMG_WIDTH);
    localparam logic [CW-1:0] THREE = CW'(3*IMG_WIDTH);
    localparam logic [CW-1:0] LINE  = CW'(IMG_WIDTH);
    localparam logic [PW-1:0] RLAST = PW'(IMG_WIDTH-3);
    localparam logic [PW-1:0] WLAST = PW'(IMG_WIDTH-1);

    typedef enum logic {IDLE, RD} state_t;

    state_t               state, state_nxt;
    logic [PIX_W-1:0]     mem [4][IMG_WIDTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [1:0]           wr_sel, rd_sel;
    logic [CW-1:0]        count;
    logic                 rd_issue, release_line, wr_accept, wr_wrap;
    logic [9*PIX_W-1:0]   win;

    // Read issue, line release, write acceptance and next state; a write may land in the line being released this cycle
    always_comb begin
        rd_issue     = (state == RD);
        release_line = rd_issue && (rd_ptr == RLAST);
        wr_accept    = i_pixel_valid && ((count < FULL) || release_line);
        wr_wrap      = (wr_ptr == WLAST);
        state_nxt    = (state == IDLE) ? ((count >= THREE && i_rd_en) ? RD : IDLE)
                                       : (release_line ? IDLE : RD);
    end

    // Gather the 3x3 window at column rd_ptr from the three oldest buffered lines
    always_comb begin
        win = '0;
        for (int l = 0; l < 3; l++)
            for (int j = 0; j < 3; j++)
                win[(l*3+j)*PIX_W +: PIX_W] = mem[rd_sel + 2'(l)][rd_ptr + PW'(j)];
    end

    // Line buffer storage; contents need no reset
    always_ff @(posedge i_clk)
        if (wr_accept) mem[wr_sel][wr_ptr] <= i_pixel_data;

    // Pointers, fill count, FSM state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            wr_sel         <= '0;
            rd_ptr         <= '0;
            rd_sel         <= '0;
            count          <= '0;
            o_window_data  <= '0;
            o_window_valid <= 1'b0;
            o_line_done    <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_accept) begin
                wr_ptr <= wr_wrap ? '0 : wr_ptr + 1'b1;
                wr_sel <= wr_sel + 2'(wr_wrap);
            end
            if (rd_issue) begin
                rd_ptr        <= release_line ? '0 : rd_ptr + 1'b1;
                rd_sel        <= rd_sel + 2'(release_line);
                o_window_data <= win;
            end
            count          <= count + CW'(wr_accept) - (release_line ? LINE : '0);
            o_window_valid <= rd_issue;
            o_line_done    <= release_line;
            o_overflow     <= o_overflow | (i_pixel_valid && !wr_accept);
        end
    end
endmodule
